mult9_engine: RTL and testbench
===============================

# mult9_engine

Nine-tap signed multiply-and-sum responder for the tensor datapath. It samples nine weight/pixel operand pairs whenever an initiator (dense or conv sequencer) raises `go`, and returns their saturated dot product on `Y1` two clocks later. It is fully pipelined, accepts one job per cycle, and keeps a sticky overflow flag and a completed-job counter for debug readback.

## Interface
- `SIZE_1`, default 11: operand width in bits (signed two's complement).
- `SIZE_CNT`, default 16: job counter width in bits.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `mult_en`  in  1  pipeline enable; low flushes in-flight jobs.
- `go`  in  1  job request, sampled on a rising edge while `mult_en`=1.
- `w11..w19`  in  SIZE_1 each  signed weights.
- `p11..p19`  in  SIZE_1 each  signed pixels.
- `Y1`  out  2*SIZE_1-1  signed saturated dot product; holds until the next result.
- `y_valid`  out  1  one-cycle pulse, high in the cycle `Y1` carries a new result.
- `busy`  out  1  high while any job is in flight (stage-1 valid OR stage-2 valid).
- `ovf`  out  1  sticky; set when any result saturated.
- `ovf_clr`  in  1  synchronous clear of `ovf`.
- `jobs`  out  SIZE_CNT  count of completed jobs; wraps modulo 2^SIZE_CNT.

## Operation
- **Stage 1 (product):** on an edge with `go`=1 and `mult_en`=1, register the nine products `wk*pk`, each full 2*SIZE_1 bits signed. Set `v1`=1. Otherwise `v1`=0 and the product registers hold.
- **Stage 2 (sum):** on an edge with `v1`=1 and `mult_en`=1:
  - Sum the nine products at 2*SIZE_1+4 bits signed; no intermediate truncation.
  - Saturate to the range [-(2^(2*SIZE_1-2)), 2^(2*SIZE_1-2)-1] and register into `Y1`.
  - Pulse `y_valid`=1 and increment `jobs`.
  - If saturation occurred, set `ovf`.
- **Hold:** `Y1` is unchanged when no result completes.
- **Flush (`mult_en`=0):** clear `v1` and `y_valid` on the next edge; products, `Y1`, `ovf` and `jobs` hold; `go` is ignored.
- **`ovf` priority:** if `ovf_clr`=1 and a saturating result completes on the same edge, `ovf` ends set (set wins).
- **Back-to-back jobs:** consecutive `go` cycles produce consecutive `y_valid` pulses in the same order; no job is dropped.
- **Outputs are registers:** nothing is combinational from inputs.
- **Reset:** `rst`=1 asynchronously clears `Y1`=0, `y_valid`=0, `busy`=0, `ovf`=0, `jobs`=0, `v1`=0 and all product registers. A job in flight at reset is discarded. Operation resumes on the first edge after `rst` falls.

## Timing
- Latency is 2 edges. With `go` sampled at edge k, the result appears after edge k+1; `y_valid` is high between edge k+1 and edge k+2.
- Throughput is 1 job per clock.
- `busy` rises after edge k and falls after the edge on which the last job's `y_valid` pulse is removed.
- `jobs` increments on the same edge that raises `y_valid`.
- `mult_en` falling at edge k+1 while a job sits in stage 1: that job is lost and no `y_valid` pulse is produced.
- Initiators must hold operands stable only at the sampling edge.

## Test plan
- **Basic dot product (SIZE_1=11):** wk=k for k=1..9, all pk=1, single `go` → 2 edges later `Y1`=45, one `y_valid` pulse, `jobs`=1, `ovf`=0.
- **Signed arithmetic:** wk=-3, pk=7 for all taps → `Y1`=-189; then wk=-1024, pk=-1024 on one tap, others 0 → `Y1`=1048576 saturates to 1048575, `ovf`=1.
- **Saturation both rails:** all w=p=1023 → `Y1`=1048575, `ovf`=1. Then `ovf_clr` pulse → `ovf`=0. Then all w=1023, p=-1024 → `Y1`=-1048576, `ovf`=1.
- **Back-to-back jobs:** `go` held for 4 cycles with pk=1 and wk=n on job n (n=1..4) → `Y1` sequence 9, 18, 27, 36 on consecutive cycles, `y_valid` high for 4 cycles, `jobs`=4.
- **Flush and reset mid-operation:** `go` at edge k, `mult_en`=0 at edge k+1 → no `y_valid`, `Y1` keeps its prior value. Then `go` again, `rst` pulsed between the two edges → all outputs 0 immediately and no result appears.
- **Counter wrap and simultaneous clear/set:** preload `jobs` to 65535 by running 65535 jobs, run one more → `jobs`=0. `ovf_clr`=1 on the same edge as a saturating result → `ovf`=1.

Source files
------------

// File: rtl/mult9_engine.sv
// mult9_engine
//   Nine-tap signed multiply-and-sum responder. Samples nine weight/pixel
//   pairs on a rising edge where go=1 and mult_en=1. Returns the saturated
//   dot product on Y1 two edges later. Fully pipelined: one job per clock.
//
// Ports
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   mult_en           pipeline enable; low flushes in-flight jobs
//   go                job request
//   w11..w19          signed weights, SIZE_1 bits each
//   p11..p19          signed pixels, SIZE_1 bits each
//   Y1                signed saturated dot product, 2*SIZE_1-1 bits (held)
//   y_valid           one-cycle pulse when Y1 carries a new result
//   busy              a job is in stage 1 or stage 2
//   ovf / ovf_clr     sticky saturation flag / synchronous clear
//   jobs              completed-job counter, wraps
module mult9_engine #(
  parameter int SIZE_1   = 11,
  parameter int SIZE_CNT = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       mult_en,
  input  logic                       go,
  input  logic signed [SIZE_1-1:0]   w11,
  input  logic signed [SIZE_1-1:0]   w12,
  input  logic signed [SIZE_1-1:0]   w13,
  input  logic signed [SIZE_1-1:0]   w14,
  input  logic signed [SIZE_1-1:0]   w15,
  input  logic signed [SIZE_1-1:0]   w16,
  input  logic signed [SIZE_1-1:0]   w17,
  input  logic signed [SIZE_1-1:0]   w18,
  input  logic signed [SIZE_1-1:0]   w19,
  input  logic signed [SIZE_1-1:0]   p11,
  input  logic signed [SIZE_1-1:0]   p12,
  input  logic signed [SIZE_1-1:0]   p13,
  input  logic signed [SIZE_1-1:0]   p14,
  input  logic signed [SIZE_1-1:0]   p15,
  input  logic signed [SIZE_1-1:0]   p16,
  input  logic signed [SIZE_1-1:0]   p17,
  input  logic signed [SIZE_1-1:0]   p18,
  input  logic signed [SIZE_1-1:0]   p19,
  output logic signed [2*SIZE_1-2:0] Y1,
  output logic                       y_valid,
  output logic                       busy,
  output logic                       ovf,
  input  logic                       ovf_clr,
  output logic [SIZE_CNT-1:0]        jobs
);

  localparam int PW    = 2 * SIZE_1;      // full product width
  localparam int SUM_W = 2 * SIZE_1 + 4;  // nine-term sum, no truncation
  localparam int YW    = 2 * SIZE_1 - 1;  // result width

  // Saturation rails are exactly the representable range of Y1.
  localparam logic signed [SUM_W-1:0] SAT_MAX = {{(SUM_W-YW+1){1'b0}}, {(YW-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] SAT_MIN = ~SAT_MAX;

  logic signed [SIZE_1-1:0] w_arr [9];
  logic signed [SIZE_1-1:0] p_arr [9];
  logic signed [PW-1:0]     prod  [9];
  logic                     v1;
  logic signed [SUM_W-1:0]  sum;
  logic signed [YW-1:0]     sat_val;
  logic                     sat_hit;

  always_comb begin
    w_arr[0] = w11; w_arr[1] = w12; w_arr[2] = w13;
    w_arr[3] = w14; w_arr[4] = w15; w_arr[5] = w16;
    w_arr[6] = w17; w_arr[7] = w18; w_arr[8] = w19;
    p_arr[0] = p11; p_arr[1] = p12; p_arr[2] = p13;
    p_arr[3] = p14; p_arr[4] = p15; p_arr[5] = p16;
    p_arr[6] = p17; p_arr[7] = p18; p_arr[8] = p19;
  end

  // Stage-2 combinational sum and saturation.
  always_comb begin
    sum = '0;
    for (int unsigned i = 0; i < 9; i++) begin
      sum = sum + SUM_W'(prod[i]);
    end
    sat_hit = 1'b0;
    if (sum > SAT_MAX) begin
      sat_val = {1'b0, {(YW-1){1'b1}}};
      sat_hit = 1'b1;
    end else if (sum < SAT_MIN) begin
      sat_val = {1'b1, {(YW-1){1'b0}}};
      sat_hit = 1'b1;
    end else begin
      sat_val = sum[YW-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1      <= 1'b0;
      Y1      <= '0;
      y_valid <= 1'b0;
      ovf     <= 1'b0;
      jobs    <= '0;
      for (int unsigned i = 0; i < 9; i++) begin
        prod[i] <= '0;
      end
    end else begin
      // Stage 1: capture products.
      if (mult_en && go) begin
        v1 <= 1'b1;
        for (int unsigned i = 0; i < 9; i++) begin
          prod[i] <= PW'(w_arr[i]) * PW'(p_arr[i]);
        end
      end else begin
        v1 <= 1'b0;
      end

      // Stage 2: sum, saturate, count.
      if (mult_en && v1) begin
        Y1      <= sat_val;
        y_valid <= 1'b1;
        jobs    <= jobs + SIZE_CNT'(1);
      end else begin
        y_valid <= 1'b0;
      end

      // A saturating completion beats a simultaneous clear.
      if (mult_en && v1 && sat_hit) begin
        ovf <= 1'b1;
      end else if (ovf_clr) begin
        ovf <= 1'b0;
      end
    end
  end

  assign busy = v1 | y_valid;

endmodule

// File: tb/tb_mult9_engine.sv
// Testbench for mult9_engine: directed scenarios plus randomized jobs,
// checked against a plain-arithmetic dot-product/saturation model.
module tb_mult9_engine;

  localparam longint MAXV = (64'sd1 <<< 20) - 1;
  localparam longint MINV = -(64'sd1 <<< 20);

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               mult_en = 1'b0;
  logic               go = 1'b0;
  logic               ovf_clr = 1'b0;
  logic signed [10:0] w [9];
  logic signed [10:0] p [9];
  logic signed [20:0] y1;
  logic               y_valid, busy, ovf;
  logic [15:0]        jobs;

  int checks = 0;
  int errors = 0;

  // model state
  longint      exp_y = 0;
  logic        exp_ovf = 1'b0;
  logic [15:0] exp_jobs = '0;

  always #5 clk = ~clk;

  mult9_engine #(.SIZE_1(11), .SIZE_CNT(16)) dut (
    .clk(clk), .rst(rst), .mult_en(mult_en), .go(go),
    .w11(w[0]), .w12(w[1]), .w13(w[2]), .w14(w[3]), .w15(w[4]),
    .w16(w[5]), .w17(w[6]), .w18(w[7]), .w19(w[8]),
    .p11(p[0]), .p12(p[1]), .p13(p[2]), .p14(p[3]), .p15(p[4]),
    .p16(p[5]), .p17(p[6]), .p18(p[7]), .p19(p[8]),
    .Y1(y1), .y_valid(y_valid), .busy(busy), .ovf(ovf), .ovf_clr(ovf_clr),
    .jobs(jobs)
  );

  function automatic longint dot();
    longint s = 0;
    for (int i = 0; i < 9; i++) s += longint'(w[i]) * longint'(p[i]);
    return s;
  endfunction

  function automatic longint clamp(input longint s);
    if (s > MAXV) return MAXV;
    if (s < MINV) return MINV;
    return s;
  endfunction

  function automatic logic sat(input longint s);
    return (s > MAXV) || (s < MINV);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_all(input int wv, input int pv);
    for (int i = 0; i < 9; i++) begin
      w[i] = 11'(wv);
      p[i] = 11'(pv);
    end
  endtask

  task automatic chk_out(input string name);
    checks++;
    if (longint'(y1) !== exp_y) begin
      errors++; $display("FAIL %s Y1 got %0d exp %0d", name, y1, exp_y);
    end
    checks++;
    if (ovf !== exp_ovf) begin
      errors++; $display("FAIL %s ovf got %b exp %b", name, ovf, exp_ovf);
    end
    checks++;
    if (jobs !== exp_jobs) begin
      errors++; $display("FAIL %s jobs got %0d exp %0d", name, jobs, exp_jobs);
    end
  endtask

  // One isolated job through the pipe, checked at every stage.
  task automatic run_job(input string name);
    longint s;
    s = dot();
    go = 1'b1;
    step();
    go = 1'b0;
    checks++;
    if (busy !== 1'b1 || y_valid !== 1'b0) begin
      errors++; $display("FAIL %s stage1 busy=%b y_valid=%b exp 1/0", name, busy, y_valid);
    end
    step();
    exp_y = clamp(s);
    if (sat(s)) exp_ovf = 1'b1;
    exp_jobs = exp_jobs + 16'd1;
    checks++;
    if (y_valid !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL %s result y_valid=%b busy=%b exp 1/1", name, y_valid, busy);
    end
    chk_out(name);
    step();
    checks++;
    if (y_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL %s drain y_valid=%b busy=%b exp 0/0", name, y_valid, busy);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #3;
    rst = 1'b0;
    exp_y = 0; exp_ovf = 1'b0; exp_jobs = '0;
  endtask

  task automatic test_reset();
    set_all(0, 0);
    mult_en = 1'b1;
    #2;
    do_reset();
    step();
    checks++;
    if (y_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL reset y_valid=%b busy=%b exp 0/0", y_valid, busy);
    end
    chk_out("reset");
  endtask

  task automatic test_basic();
    for (int i = 0; i < 9; i++) begin
      w[i] = 11'(i + 1);
      p[i] = 11'sd1;
    end
    run_job("basic45");
    checks++;
    if (longint'(y1) !== 64'sd45) begin
      errors++; $display("FAIL basic_const Y1 got %0d exp 45", y1);
    end
  endtask

  task automatic test_signed();
    set_all(-3, 7);
    run_job("signed_m189");
    set_all(0, 0);
    w[4] = -11'sd1024;
    p[4] = -11'sd1024;
    run_job("signed_sat");
  endtask

  task automatic test_saturation();
    set_all(1023, 1023);
    run_job("sat_pos");
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    exp_ovf = 1'b0;
    chk_out("ovf_clr");
    set_all(1023, -1024);
    run_job("sat_neg");
  endtask

  task automatic test_back_to_back();
    set_all(0, 1);
    go = 1'b1;
    for (int n = 1; n <= 6; n++) begin
      if (n <= 4) begin
        for (int i = 0; i < 9; i++) w[i] = 11'(n);
      end else begin
        go = 1'b0;
      end
      step();
      if (n >= 2 && n <= 5) begin
        exp_y = 9 * (n - 1);
        exp_jobs = exp_jobs + 16'd1;
        checks++;
        if (y_valid !== 1'b1) begin
          errors++; $display("FAIL b2b_valid cycle %0d got %b exp 1", n, y_valid);
        end
        chk_out("b2b");
      end else if (n == 6) begin
        checks++;
        if (y_valid !== 1'b0) begin
          errors++; $display("FAIL b2b_end y_valid got %b exp 0", y_valid);
        end
      end
    end
  endtask

  task automatic test_flush_and_reset();
    set_all(5, 5);
    go = 1'b1;
    step();
    go = 1'b0;
    mult_en = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (y_valid !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL flush y_valid=%b busy=%b exp 0/0", y_valid, busy);
      end
      chk_out("flush_hold");
    end
    mult_en = 1'b1;
    go = 1'b1;
    step();
    go = 1'b0;
    #2;
    do_reset();
    checks++;
    if (y_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL midreset y_valid=%b busy=%b exp 0/0", y_valid, busy);
    end
    chk_out("midreset");
    for (int c = 0; c < 2; c++) begin
      step();
      checks++;
      if (y_valid !== 1'b0) begin
        errors++; $display("FAIL midreset_nores y_valid got %b exp 0", y_valid);
      end
    end
  endtask

  typedef struct { int due; longint val; } job_t;

  task automatic test_random();
    job_t q[$];
    int   cyc = 0;
    for (int it = 0; it < 300; it++) begin
      go = (it < 296) && ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 9; i++) begin
        if ($urandom_range(0, 1) == 1) begin
          w[i] = 11'($urandom);
          p[i] = 11'($urandom);
        end else begin
          w[i] = 11'($signed($urandom_range(0, 200)) - 100);
          p[i] = 11'($signed($urandom_range(0, 200)) - 100);
        end
      end
      if (go) q.push_back('{cyc + 2, dot()});
      step();
      cyc++;
      if (q.size() > 0 && q[0].due == cyc) begin
        exp_y = clamp(q[0].val);
        if (sat(q[0].val)) exp_ovf = 1'b1;
        exp_jobs = exp_jobs + 16'd1;
        void'(q.pop_front());
        checks++;
        if (y_valid !== 1'b1) begin
          errors++; $display("FAIL rand_valid cyc %0d got %b exp 1", cyc, y_valid);
        end
      end else begin
        checks++;
        if (y_valid !== 1'b0) begin
          errors++; $display("FAIL rand_idle cyc %0d got %b exp 0", cyc, y_valid);
        end
      end
      chk_out("rand");
    end
  endtask

  task automatic test_wrap_and_clr();
    do_reset();
    set_all(0, 0);
    go = 1'b1;
    for (int i = 0; i < 65535; i++) step();
    go = 1'b0;
    step();
    step();
    exp_y = 0;
    exp_jobs = 16'hFFFF;
    chk_out("jobs_65535");
    run_job("jobs_wrap");
    checks++;
    if (jobs !== 16'd0) begin
      errors++; $display("FAIL wrap jobs got %0d exp 0", jobs);
    end
    set_all(1023, 1023);
    go = 1'b1;
    step();
    go = 1'b0;
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    exp_y = MAXV;
    exp_ovf = 1'b1;
    exp_jobs = exp_jobs + 16'd1;
    chk_out("clr_set_same_edge");
  endtask

  initial begin
    set_all(0, 0);
    test_reset();
    test_basic();
    test_signed();
    test_saturation();
    test_back_to_back();
    test_flush_and_reset();
    test_random();
    test_wrap_and_clr();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
